// File: rtl/mac_acc_pkg.sv
// Shared types, constants and helpers for the signed MAC accumulator.
package mac_acc_pkg;

    // Frame control states.
    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StHold
    } state_e;

    localparam int unsigned PROD_W        = 64;
    localparam int unsigned LEN_DEFAULT   = 16;
    localparam int unsigned ACC_W_DEFAULT = 72;
    localparam int unsigned ACC_W_MAX     = 128;

    // Ceiling log2; returns 0 for value <= 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 0;
        while ((64'd1 << res) < 64'(value)) begin
            res = res + 1;
        end
        return res;
    endfunction

    // Most positive signed value of a w-bit word, zero-extended to ACC_W_MAX bits.
    function automatic logic [ACC_W_MAX-1:0] sat_pos(input int unsigned w);
        logic [ACC_W_MAX-1:0] one;
        one = 1;
        return (one << (w - 1)) - one;
    endfunction

    // Most negative signed value of a w-bit word (only the low w bits are meaningful).
    function automatic logic [ACC_W_MAX-1:0] sat_neg(input int unsigned w);
        return ~sat_pos(w);
    endfunction

endpackage

// File: rtl/signed_mac_accumulator_64bit_sat_add.sv
// Combinational ACC_W-bit signed adder with optional saturation.
module sat_add_signed
    import mac_acc_pkg::*;
#(
    parameter int unsigned ACC_W = ACC_W_DEFAULT,
    parameter bit          SAT   = 1'b1
) (
    input  logic [ACC_W-1:0] a,
    input  logic [ACC_W-1:0] b,
    output logic [ACC_W-1:0] sum,
    output logic             ovf
);

    localparam logic [ACC_W-1:0] MaxPos = ACC_W'(sat_pos(ACC_W));
    localparam logic [ACC_W-1:0] MinNeg = ACC_W'(sat_neg(ACC_W));

    logic [ACC_W:0] wide;

    // One-bit-wider add; the two top bits disagree exactly on signed overflow.
    always_comb begin
        wide = {a[ACC_W-1], a} + {b[ACC_W-1], b};
        ovf  = wide[ACC_W] ^ wide[ACC_W-1];
        sum  = wide[ACC_W-1:0];
        if (ovf && SAT) begin
            // wide[ACC_W] carries the true sign of the unbounded result.
            sum = wide[ACC_W] ? MinNeg : MaxPos;
        end
    end

endmodule

// File: rtl/signed_mac_accumulator_64bit.sv
// Accumulates LEN signed 64-bit products into one frame sum and presents it on valid/ready.
module signed_mac_accumulator_64bit
    import mac_acc_pkg::*;
#(
    parameter int unsigned LEN   = LEN_DEFAULT,
    parameter int unsigned ACC_W = ACC_W_DEFAULT,
    parameter bit          SAT   = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [PROD_W-1:0]          prod,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       clear,
    output logic [ACC_W-1:0]           acc_out,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       overflow,
    output logic [clog2(LEN+1)-1:0]    term_cnt
);

    localparam int unsigned     CntW    = clog2(LEN + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(LEN - 1);

    state_e            state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [ACC_W-1:0]  acc_out_q, acc_out_d;
    logic              out_valid_q, out_valid_d;
    logic              ovf_q, ovf_d;
    logic [CntW-1:0]   cnt_q, cnt_d;

    logic [ACC_W-1:0]  prod_ext;
    logic [ACC_W-1:0]  add_sum;
    logic              add_ovf;
    logic              accept;

    assign prod_ext = ACC_W'($signed(prod));
    assign in_ready = (state_q != StHold);
    assign accept   = in_valid & in_ready;

    assign acc_out   = acc_out_q;
    assign out_valid = out_valid_q;
    assign overflow  = ovf_q;
    assign term_cnt  = cnt_q;

    sat_add_signed #(
        .ACC_W (ACC_W),
        .SAT   (SAT)
    ) u_add (
        .a   (acc_q),
        .b   (prod_ext),
        .sum (add_sum),
        .ovf (add_ovf)
    );

    // Next-state: clear beats everything; acc_q is always zero in StIdle, so the first
    // beat goes through the same adder as the rest.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        acc_out_d   = acc_out_q;
        out_valid_d = out_valid_q;
        ovf_d       = ovf_q;
        cnt_d       = cnt_q;
        if (clear) begin
            state_d     = StIdle;
            acc_d       = '0;
            cnt_d       = '0;
            ovf_d       = 1'b0;
            out_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StAccum: begin
                    if (accept) begin
                        acc_d = add_sum;
                        cnt_d = cnt_q + CntW'(1);
                        ovf_d = ovf_q | add_ovf;
                        if (cnt_q == LastCnt) begin
                            state_d     = StHold;
                            acc_out_d   = add_sum;
                            out_valid_d = 1'b1;
                        end else begin
                            state_d = StAccum;
                        end
                    end
                end
                StHold: begin
                    if (out_ready) begin
                        state_d     = StIdle;
                        acc_d       = '0;
                        cnt_d       = '0;
                        ovf_d       = 1'b0;
                        out_valid_d = 1'b0;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            acc_q       <= '0;
            acc_out_q   <= '0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            acc_out_q   <= acc_out_d;
            out_valid_q <= out_valid_d;
            ovf_q       <= ovf_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule

// File: doc/signed_mac_accumulator_64bit.md
Name: signed_mac_accumulator_64bit

Overview:
Downstream stage of signed_vedic_mult_32bit. It consumes the 64-bit signed products, one per accepted beat, and accumulates LEN of them into a wider signed sum (a dot-product frame). It then presents the frame result on a valid/ready output and holds it until taken. Saturation and overflow flagging keep long frames safe for the accumulator datapath.

Parameters:
LEN, 16, number of products per frame (≥1)
ACC_W, 72, accumulator width in bits (≥64)
SAT, 1, 1 = saturate on signed overflow; 0 = two's-complement wrap

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
prod  input  64  signed product from signed_vedic_mult_32bit.out
in_valid  input  1  prod is valid this cycle
in_ready  output  1  block accepts prod this cycle
clear  input  1  synchronous frame abort
acc_out  output  ACC_W  signed frame sum, registered
out_valid  output  1  acc_out holds a completed frame
out_ready  input  1  consumer takes acc_out
overflow  output  1  sticky per-frame flag: saturation or wrap occurred
term_cnt  output  clog2(LEN+1)  products accepted in current frame

Behaviour:
- Reset (rst=1, async): state=IDLE, acc=0, acc_out=0, out_valid=0, overflow=0, term_cnt=0. in_ready is 1 once rst deasserts.
- Accept = in_valid & in_ready. No other event consumes prod.
- States:
  - IDLE: in_ready=1. On accept: acc=sext(prod), term_cnt=1, go to ACCUM. If LEN==1, go straight to HOLD.
  - ACCUM: in_ready=1. On accept: acc=acc+sext(prod) (saturating per SAT), term_cnt++. On the LEN-th accept: go to HOLD, load acc_out with the new sum, out_valid=1 on the next cycle. The result is visible 1 cycle after the final accept.
  - HOLD: in_ready=0, out_valid=1, acc_out and overflow stable. On out_ready=1: out_valid=0, acc=0, term_cnt=0, overflow=0, go to IDLE. in_ready stays 0 during the handshake cycle, so there is one bubble cycle per frame.
- Arithmetic:
  - prod is sign-extended to ACC_W+1 bits and added.
  - Signed overflow occurs when the two operand sign bits are equal and the result sign differs.
  - SAT=1: clamp to +2^(ACC_W-1)-1 or -2^(ACC_W-1), and set overflow.
  - SAT=0: wrap, and set overflow.
  - overflow stays set until the frame is consumed or cleared.
- clear=1 (synchronous, highest priority, any state):
  - acc=0, term_cnt=0, overflow=0, out_valid=0, go to IDLE.
  - A simultaneous accept is dropped.
  - A simultaneous out_ready in HOLD is ignored; the frame is discarded.
- in_valid while in_ready=0 means the beat is not consumed. The producer must hold prod.
- Reset mid-frame discards all partial state immediately.
- acc_out keeps its last value after consumption until the next frame completes. Consumers must qualify it with out_valid.

Decomposition:
- Package mac_acc_pkg:
  - state enum {IDLE, ACCUM, HOLD}
  - helper function clog2
  - localparams for max/min saturation constants derived from ACC_W
- Sub-module sat_add_signed: combinational ACC_W-bit signed adder. Parameters ACC_W and SAT; outputs sum and ovf. It is instantiated once in the top.

Test Plan:
1. LEN=4, products 6, -6 (0xFFFF_FFFF_FFFF_FFFA), -6, 6 on back-to-back cycles, out_ready=1 -> out_valid one cycle after 4th accept, acc_out=0, overflow=0, in_ready low exactly in the HOLD cycle.
2. LEN=4, products 6, 6, 6, 6, out_ready=0 for 5 cycles -> acc_out=24 held stable with out_valid=1 and in_ready=0 throughout. A 5th in_valid is not accepted until after out_ready.
3. ACC_W=64, SAT=1, LEN=2, products 0x7FFF_FFFF_FFFF_FFFF twice -> acc_out=0x7FFF_FFFF_FFFF_FFFF, overflow=1. With SAT=0 -> acc_out=0xFFFF_FFFF_FFFF_FFFE, overflow=1.
4. LEN=4, accept 6, 6, then clear=1 together with in_valid (prod=6) -> term_cnt=0, beat dropped. The next four products 1, 2, 3, 4 -> acc_out=10.
5. Assert rst asynchronously mid-frame (term_cnt=2) and mid-HOLD -> all outputs zero within the same cycle, in_ready=1 after release.
6. LEN=1, product -6 -> out_valid the next cycle with acc_out=sext(-6) (all ones except bit pattern ...FFFA), IDLE goes directly to HOLD.
